i2c_slave: RTL and testbench

I2C target (slave) that responds to a 7-bit address, receives write bytes and serves read bytes.
- SCL/SDA are oversampled on clk_i; start, stop and repeated start are detected from the filtered lines.
- Write data is presented on a one-cycle valid strobe; read data is fetched from a local source through a valid/ready pull.
- Pairs with the team's i2c_master on the same bus; open-drain SDA, no clock stretching.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_slave_line_filter.sv | 60 ++++++
 rtl/i2c_slave.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target state encoding, bus constants and address helper.
package i2c_pkg;

    localparam int   I2C_ADDR_WIDTH = 7;
    localparam int   I2C_BYTE_WIDTH = 8;
    localparam logic I2C_DIR_WRITE  = 1'b0;
    localparam logic I2C_DIR_READ   = 1'b1;
    localparam logic I2C_ACK        = 1'b0;
    localparam logic I2C_NACK       = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_SKIP      = 3'd7
    } i2c_slave_state_t;

    // General call (address 0) is not served, so it never counts as a match.
    function automatic logic addr_match(input logic [I2C_ADDR_WIDTH-1:0] rx_addr,
                                        input logic [I2C_ADDR_WIDTH-1:0] own_addr);
        return (rx_addr == own_addr) && (rx_addr != 7'd0);
    endfunction

endpackage

// File: rtl/i2c_slave_line_filter.sv
// Two-flop synchronizer plus stability filter for one open-drain bus line.
// The filtered value only follows the synchronized line after it has held a
// new level for FILTER_LEN consecutive cycles; rise/fall flags last one cycle.
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             filt_r;
    logic             rise_r;
    logic             fall_r;

    // Bring the asynchronous line into the clk_i domain; idle bus level is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], line_i};
        end
    end

    // Accept a new level only after it has been stable long enough; flag the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_r <= 1'b1;
            cnt_r  <= {CNT_W{1'b0}};
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (sync_r[1] == filt_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                filt_r <= sync_r[1];
                cnt_r  <= {CNT_W{1'b0}};
                rise_r <= sync_r[1];
                fall_r <= ~sync_r[1];
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    assign filt_o = filt_r;
    assign rise_o = rise_r;
    assign fall_o = fall_r;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, write bytes out on a strobe, read bytes
// pulled through a valid/ready handshake. Open-drain SDA, no clock stretching.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = I2C_BYTE_WIDTH,
    parameter int ADDR_WIDTH = I2C_ADDR_WIDTH,
    parameter int FILTER_LEN = 4
) (
    input  logic                  clk_i,
    input  logic                  a_rst_i,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] own_addr_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  busy_o
);

    // Address byte (address + R/W) and data byte share one bit counter.
    localparam logic [3:0] ADDR_LAST = 4'(ADDR_WIDTH);
    localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);

    logic scl_filt_s, scl_rise_s, scl_fall_s;
    logic sda_filt_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk_i  (clk_i),
        .rst_i  (a_rst_i),
        .line_i (scl_i),
        .filt_o (scl_filt_s),
        .rise_o (scl_rise_s),
        .fall_o (scl_fall_s)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk_i  (clk_i),
        .rst_i  (a_rst_i),
        .line_i (sda_i),
        .filt_o (sda_filt_s),
        .rise_o (sda_rise_s),
        .fall_o (sda_fall_s)
    );

    assign start_s = sda_fall_s & scl_filt_s;
    assign stop_s  = sda_rise_s & scl_filt_s;

    i2c_slave_state_t        state_r, state_s;
    logic [3:0]              bit_cnt_r, bit_cnt_s;
    logic [DATA_WIDTH-2:0]   shift_r, shift_s;      // bits collected so far
    logic [DATA_WIDTH-2:0]   tx_shift_r, tx_shift_s; // read bits still to drive
    logic [ADDR_WIDTH-1:0]   own_addr_r, own_addr_s;
    logic                    rw_r, rw_s;
    logic                    sda_r, sda_s;
    logic [DATA_WIDTH-1:0]   rx_data_r, rx_data_s;
    logic                    rx_valid_r, rx_valid_s;
    logic                    tx_ready_r, tx_ready_s;
    logic                    busy_r, busy_s;
    logic [DATA_WIDTH-1:0]   shift_in_s;
    logic [DATA_WIDTH-1:0]   tx_byte_s;

    // State and output registers; reset releases SDA immediately.
    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= {(DATA_WIDTH-1){1'b0}};
            tx_shift_r <= {(DATA_WIDTH-1){1'b1}};
            own_addr_r <= {ADDR_WIDTH{1'b0}};
            rw_r       <= I2C_DIR_WRITE;
            sda_r      <= 1'b1;
            rx_data_r  <= {DATA_WIDTH{1'b0}};
            rx_valid_r <= 1'b0;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            tx_shift_r <= tx_shift_s;
            own_addr_r <= own_addr_s;
            rw_r       <= rw_s;
            sda_r      <= sda_s;
            rx_data_r  <= rx_data_s;
            rx_valid_r <= rx_valid_s;
            tx_ready_r <= tx_ready_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state logic: enable, stop and start take priority over bit handling.
    // SDA is only ever updated on scl_fall (or released on start/stop), so it
    // never moves while SCL is high. In the ACK states bit_cnt_r tells the
    // first falling edge (begin ACK bit) from the second (end of ACK bit).
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        tx_shift_s = tx_shift_r;
        own_addr_s = own_addr_r;
        rw_s       = rw_r;
        sda_s      = sda_r;
        rx_data_s  = rx_data_r;
        rx_valid_s = 1'b0;
        tx_ready_s = 1'b0;
        busy_s     = busy_r;
        shift_in_s = {shift_r, sda_filt_s};
        if (tx_valid_i) begin
            tx_byte_s = tx_data_i;
        end else begin
            tx_byte_s = {DATA_WIDTH{1'b1}};
        end

        if (!en_i) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 4'd0;
            sda_s     = 1'b1;
            busy_s    = 1'b0;
        end else if (stop_s) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 4'd0;
            sda_s     = 1'b1;
            busy_s    = 1'b0;
        end else if (start_s) begin
            state_s    = ST_ADDR;
            bit_cnt_s  = 4'd0;
            sda_s      = 1'b1;
            own_addr_s = own_addr_i;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sda_s = 1'b1;
                end
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_s = shift_in_s[DATA_WIDTH-2:0];
                        if (bit_cnt_r == ADDR_LAST) begin
                            bit_cnt_s = 4'd0;
                            rw_s      = shift_in_s[0];
                            if (addr_match(shift_in_s[DATA_WIDTH-1 -: ADDR_WIDTH], own_addr_r)) begin
                                state_s = ST_ADDR_ACK;
                                busy_s  = 1'b1;
                            end else begin
                                state_s = ST_SKIP;
                                busy_s  = 1'b0;
                            end
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd0) begin
                            sda_s     = I2C_ACK;
                            bit_cnt_s = 4'd1;
                        end else if (rw_r == I2C_DIR_READ) begin
                            state_s    = ST_READ;
                            bit_cnt_s  = 4'd0;
                            sda_s      = tx_byte_s[DATA_WIDTH-1];
                            tx_shift_s = tx_byte_s[DATA_WIDTH-2:0];
                            tx_ready_s = tx_valid_i;
                        end else begin
                            state_s   = ST_WRITE;
                            bit_cnt_s = 4'd0;
                            sda_s     = 1'b1;
                        end
                    end else begin
                        sda_s = sda_r;
                    end
                end
                ST_WRITE: begin
                    if (scl_rise_s) begin
                        shift_s = shift_in_s[DATA_WIDTH-2:0];
                        if (bit_cnt_r == DATA_LAST) begin
                            rx_data_s  = shift_in_s;
                            rx_valid_s = 1'b1;
                            state_s    = ST_WRITE_ACK;
                            bit_cnt_s  = 4'd0;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r;
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd0) begin
                            sda_s     = I2C_ACK;
                            bit_cnt_s = 4'd1;
                        end else begin
                            sda_s     = 1'b1;
                            bit_cnt_s = 4'd0;
                            state_s   = ST_WRITE;
                        end
                    end else begin
                        sda_s = sda_r;
                    end
                end
                ST_READ: begin
                    if (scl_rise_s) begin
                        if (bit_cnt_r == DATA_LAST) begin
                            state_s   = ST_READ_ACK;
                            bit_cnt_s = 4'd0;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else if (scl_fall_s) begin
                        sda_s      = tx_shift_r[DATA_WIDTH-2];
                        tx_shift_s = {tx_shift_r[DATA_WIDTH-3:0], 1'b1};
                    end else begin
                        sda_s = sda_r;
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_filt_s == I2C_NACK) begin
                            state_s = ST_SKIP;
                        end else begin
                            bit_cnt_s = 4'd1;
                        end
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd0) begin
                            sda_s = 1'b1;
                        end else begin
                            state_s    = ST_READ;
                            bit_cnt_s  = 4'd0;
                            sda_s      = tx_byte_s[DATA_WIDTH-1];
                            tx_shift_s = tx_byte_s[DATA_WIDTH-2:0];
                            tx_ready_s = tx_valid_i;
                        end
                    end else begin
                        sda_s = sda_r;
                    end
                end
                ST_SKIP: begin
                    sda_s = 1'b1;
                end
                default: begin
                    state_s = ST_IDLE;
                    sda_s   = 1'b1;
                end
            endcase
        end
    end

    assign sda_o      = sda_r;
    assign rx_data_o  = rx_data_r;
    assign rx_valid_o = rx_valid_r;
    assign tx_ready_o = tx_ready_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master drives the bus, expected
// write/read bytes go into queues, and a monitor branch pops and compares on
// every rx_valid_o / tx_ready_o strobe.
module tb_i2c_slave;

    localparam int FILTER_LEN = 4;

    logic       clk_i = 1'b0;
    logic       a_rst_i;
    logic       en_i;
    logic [6:0] own_addr_i;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       busy_o;

    int         checks = 0;
    int         failures = 0;
    int         sda_low_cnt = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];

    assign sda_bus = sda_m & sda_o;

    always #5 clk_i = ~clk_i;

    i2c_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .FILTER_LEN(FILTER_LEN)) dut (
        .clk_i      (clk_i),
        .a_rst_i    (a_rst_i),
        .en_i       (en_i),
        .own_addr_i (own_addr_i),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_o      (sda_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .busy_o     (busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(10);
        scl_m = 1'b1; wait_clk(20);
        sda_m = 1'b0; wait_clk(20);
        scl_m = 1'b0; wait_clk(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(10);
        scl_m = 1'b1; wait_clk(20);
        sda_m = 1'b1; wait_clk(20);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clk(10);
        scl_m = 1'b1; wait_clk(20);
        scl_m = 1'b0; wait_clk(10);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(10);
        scl_m = 1'b1; wait_clk(10);
        b = sda_bus;  wait_clk(10);
        scl_m = 1'b0; wait_clk(10);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] exp_b;
        int         low0;

        a_rst_i    = 1'b1;
        en_i       = 1'b1;
        own_addr_i = 7'h50;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;

        fork
            // Monitor: every output strobe is matched against the scoreboard.
            forever begin
                @(negedge clk_i);
                if (!sda_o) sda_low_cnt++;
                if (rx_valid_o) begin
                    if (exp_rx_q.size() == 0) begin
                        check("rx_valid_unexpected", 32'(rx_valid_o), 32'd0);
                    end else begin
                        exp_b = exp_rx_q.pop_front();
                        check("rx_data", 32'(rx_data_o), 32'(exp_b));
                    end
                end
                if (tx_ready_o) begin
                    if (exp_tx_q.size() == 0) begin
                        check("tx_ready_unexpected", 32'(tx_ready_o), 32'd0);
                    end else begin
                        exp_b = exp_tx_q.pop_front();
                        check("tx_consumed", 32'(tx_data_i), 32'(exp_b));
                    end
                end
            end
            begin
                // Reset values.
                wait_clk(3);
                check("rst_sda", 32'(sda_o), 32'd1);
                check("rst_rx_data", 32'(rx_data_o), 32'd0);
                check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
                check("rst_tx_ready", 32'(tx_ready_o), 32'd0);
                check("rst_busy", 32'(busy_o), 32'd0);
                a_rst_i = 1'b0;
                wait_clk(10);

                // T1: write 0xA5 to own address 0x50.
                exp_rx_q.push_back(8'hA5);
                i2c_start();
                send_byte(8'hA0, ack);
                check("t1_addr_ack", 32'(ack), 32'd0);
                check("t1_busy", 32'(busy_o), 32'd1);
                send_byte(8'hA5, ack);
                check("t1_data_ack", 32'(ack), 32'd0);
                i2c_stop();
                check("t1_busy_after_stop", 32'(busy_o), 32'd0);
                check("t1_sda_released", 32'(sda_o), 32'd1);
                check("t1_rx_pending", 32'(exp_rx_q.size()), 32'd0);

                // T2: other address 0x51, target must stay off the bus.
                low0 = sda_low_cnt;
                i2c_start();
                send_byte(8'hA2, ack);
                check("t2_addr_nack", 32'(ack), 32'd1);
                check("t2_busy", 32'(busy_o), 32'd0);
                send_byte(8'h5A, ack);
                check("t2_data_nack", 32'(ack), 32'd1);
                i2c_stop();
                check("t2_sda_never_low", 32'(sda_low_cnt - low0), 32'd0);

                // T3: read 0x3C, master NACK, then skip until stop.
                tx_data_i  = 8'h3C;
                tx_valid_i = 1'b1;
                exp_tx_q.push_back(8'h3C);
                i2c_start();
                send_byte(8'hA1, ack);
                check("t3_addr_ack", 32'(ack), 32'd0);
                recv_byte(rd);
                check("t3_read_byte", 32'(rd), 32'h3C);
                send_bit(1'b1);
                check("t3_busy_in_skip", 32'(busy_o), 32'd1);
                tx_data_i = 8'h00;
                low0 = sda_low_cnt;
                recv_byte(rd);
                check("t3_skip_released", 32'(rd), 32'hFF);
                check("t3_skip_sda_low", 32'(sda_low_cnt - low0), 32'd0);
                i2c_stop();
                check("t3_busy_after_stop", 32'(busy_o), 32'd0);
                check("t3_tx_pending", 32'(exp_tx_q.size()), 32'd0);
                tx_valid_i = 1'b0;

                // T4: write 0x11, repeated start, two reads with no data available.
                tx_data_i = 8'h77;
                exp_rx_q.push_back(8'h11);
                i2c_start();
                send_byte(8'hA0, ack);
                check("t4_waddr_ack", 32'(ack), 32'd0);
                send_byte(8'h11, ack);
                check("t4_data_ack", 32'(ack), 32'd0);
                i2c_start();
                send_byte(8'hA1, ack);
                check("t4_raddr_ack", 32'(ack), 32'd0);
                recv_byte(rd);
                check("t4_read0", 32'(rd), 32'hFF);
                send_bit(1'b0);
                recv_byte(rd);
                check("t4_read1", 32'(rd), 32'hFF);
                send_bit(1'b1);
                i2c_stop();
                check("t4_rx_pending", 32'(exp_rx_q.size()), 32'd0);

                // T5: stop after 4 data bits discards the partial byte.
                i2c_start();
                send_byte(8'hA0, ack);
                check("t5_addr_ack", 32'(ack), 32'd0);
                send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
                i2c_stop();
                check("t5_sda_released", 32'(sda_o), 32'd1);
                check("t5_busy", 32'(busy_o), 32'd0);

                // T5b: an SCL glitch of FILTER_LEN-1 cycles must not shift a bit.
                exp_rx_q.push_back(8'h5A);
                i2c_start();
                send_byte(8'hA0, ack);
                check("t5b_addr_ack", 32'(ack), 32'd0);
                sda_m = 1'b0; wait_clk(5);
                scl_m = 1'b1; wait_clk(FILTER_LEN - 1);
                scl_m = 1'b0; wait_clk(10);
                send_byte(8'h5A, ack);
                check("t5b_data_ack", 32'(ack), 32'd0);
                i2c_stop();
                check("t5b_rx_pending", 32'(exp_rx_q.size()), 32'd0);

                // T6: reset during the address ACK releases SDA asynchronously.
                i2c_start();
                for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
                check("t6_ack_driven", 32'(sda_o), 32'd0);
                check("t6_busy", 32'(busy_o), 32'd1);
                a_rst_i = 1'b1;
                #1;
                check("t6_rst_sda", 32'(sda_o), 32'd1);
                check("t6_rst_busy", 32'(busy_o), 32'd0);
                check("t6_rst_rx_data", 32'(rx_data_o), 32'd0);
                check("t6_rst_rx_valid", 32'(rx_valid_o), 32'd0);
                check("t6_rst_tx_ready", 32'(tx_ready_o), 32'd0);
                wait_clk(3);
                a_rst_i = 1'b0;
                wait_clk(10);
                exp_rx_q.push_back(8'hC3);
                i2c_start();
                send_byte(8'hA0, ack);
                check("t6_addr_ack", 32'(ack), 32'd0);
                send_byte(8'hC3, ack);
                check("t6_data_ack", 32'(ack), 32'd0);
                i2c_stop();
                wait_clk(10);

                check("end_rx_pending", 32'(exp_rx_q.size()), 32'd0);
                check("end_tx_pending", 32'(exp_tx_q.size()), 32'd0);
            end
        join_any

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
